// File: rtl/ipsec_mem_reader.sv
// rtl/ipsec_mem_reader.sv - Avalon-MM block reader re-emitting SRAM words as an Avalon-ST packet
//
// Fetches word_count words starting at base_addr (wrapping modulo 2^ADDR_W),
// one read per cycle, and streams them out with sop/eop framing. Reads are
// only issued while the output FIFO plus the in-flight read has room, so the
// FIFO can never overflow regardless of sink backpressure.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle job request, honoured only when idle
//   base_addr, word_count job parameters, latched on accepted start
//   busy, done            job in progress / one-cycle completion pulse
//   avm_*                 read initiator toward the single-port SRAM
//   st_*                  packet stream toward the IPsec datapath
module ipsec_mem_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  out_idx_q;
    logic              inflight_q;
    logic              done_q;
    logic              clken_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              last_issue;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    // Credit check counts the word still on the bus, so a read is only
    // issued when its data is guaranteed a free FIFO slot.
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue      = (state == S_ISSUE) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign last_issue = (issued_q == len_q - LEN_W'(1));
    assign fifo_empty = (fifo_count == '0);
    // readdata is valid exactly one cycle after chipselect, so the push is
    // simply the delayed chipselect.
    assign push       = inflight_q;
    assign pop        = !fifo_empty && st_ready;

    assign avm_address    = base_q + issued_q[ADDR_W-1:0];
    assign avm_chipselect = issue;
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = clken_q;

    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign st_valid = !fifo_empty;
    assign st_data  = fifo_mem[rd_ptr];
    assign st_sop   = st_valid && (out_idx_q == '0);
    assign st_eop   = st_valid && (out_idx_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            out_idx_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            clken_q    <= 1'b1;
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (pop) begin
                out_idx_q <= out_idx_q + LEN_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        len_q     <= word_count;
                        issued_q  <= '0;
                        out_idx_q <= '0;
                        if (word_count != '0) begin
                            state <= S_ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        issued_q <= issued_q + LEN_W'(1);
                        if (last_issue) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && st_eop) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= avm_readdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) begin
            assert (fifo_count < CNT_W'(FIFO_DEPTH));
        end
    end

endmodule
